tmp_bank: RTL
=============

TMP_BANK -- requirements
Module: tmp_bank

Interface
- REQ-001: Parameter WIDTH, default 8, data width of each register in bits (>=1).
- REQ-002: Parameter DEPTH, default 4, number of registers; power of two, >=2; AW = clog2(DEPTH).
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset; asynchronous, active-high.
- REQ-005: s  input  1  set strobe; write t_in into register s_addr.
- REQ-006: s_addr  input  AW  write register index.
- REQ-007: t_in  input  WIDTH  write data.
- REQ-008: e  input  1  enable; drive register e_addr onto t_out.
- REQ-009: e_addr  input  AW  read register index.
- REQ-010: bus1  input  1  force-one request (see Configuration).
- REQ-011: clr  input  1  start a sequential clear sweep of all registers.
- REQ-012: t_out  output  WIDTH  read data.
- REQ-013: busy  output  1  high while a clear sweep is in progress.

Function
- REQ-014: Write: at a rising edge with s=1 and busy=0, reg[s_addr] SHALL take t_in; the new value is visible on t_out from that edge onward (0-cycle read latency after the write edge).
- REQ-015: Read SHALL be combinational: e=1 -> t_out = reg[e_addr]; e=0 -> t_out = 0.
- REQ-016: No write bypass: with s=1, e=1, s_addr=e_addr in one cycle, t_out SHALL show the old contents until the edge.
- REQ-017: Controller FSM states IDLE and SWEEP; busy = 1 exactly in SWEEP.
- REQ-018: IDLE -> SWEEP at an edge with clr=1; the sweep index SHALL load 0.
- REQ-019: In SWEEP, each edge SHALL clear reg[index] to 0 and increment the index; the edge clearing index DEPTH-1 SHALL return the FSM to IDLE. busy is high for exactly DEPTH cycles.
- REQ-020: clr asserted during SWEEP SHALL be ignored (no restart, no extension).
- REQ-021: s asserted during SWEEP SHALL be discarded; no register changes except by the sweep.
- REQ-022: clr and s in the same IDLE cycle: clr wins; the write SHALL be discarded.
- REQ-023: Reads during SWEEP SHALL return current contents (already-cleared entries read 0, others hold old values).
- REQ-024: Index arithmetic is AW bits wide; termination SHALL be detected on index = DEPTH-1, not by wrap.

Reset
- REQ-025: rst=1 SHALL immediately force all registers to 0, FSM to IDLE, index to 0, busy to 0; t_out therefore reads 0.
- REQ-026: rst asserted mid-sweep SHALL abort the sweep; after release the block is IDLE and accepts writes on the first edge.

Configuration
- REQ-027: Macro TMP_BANK_BUS1_EN defined: bus1=1 SHALL force t_out = 1 (value one, zero-extended to WIDTH) regardless of e/e_addr; bus1=0 gives REQ-015 behaviour.
- REQ-028: Macro TMP_BANK_BUS1_EN undefined: bus1 port SHALL remain present but be ignored; t_out follows REQ-015 only.

Structure
- REQ-029: Package tmp_bank_pkg SHALL hold the FSM state type (IDLE, SWEEP) and the default WIDTH/DEPTH constants.
- REQ-030: One sub-module, tmp_bank_cell: single WIDTH-bit register with async reset, load and clear inputs; tmp_bank instantiates DEPTH copies.

Verification
- REQ-031: Write 8'h11, 8'h55, 8'haa, 8'hff to regs 0..3, then read each with e=1 -> t_out matches; e=0 -> t_out = 8'h00.
- REQ-032: s=1, e=1, both addr 2, t_in=8'h3c, reg2 = 8'haa -> t_out = 8'haa before the edge, 8'h3c after.
- REQ-033: All regs nonzero, pulse clr for one cycle -> busy high exactly 4 cycles; reg k reads 0 from sweep edge k+1; writes with s=1 during sweep leave regs unchanged; second clr mid-sweep has no effect.
- REQ-034: clr=1 and s=1 (addr 1, 8'h77) same IDLE cycle -> sweep starts, reg1 ends 8'h00.
- REQ-035: rst pulse after 2 sweep cycles -> busy drops immediately, all regs 0; first edge after release with s=1 writes normally.
- REQ-036: With TMP_BANK_BUS1_EN: bus1=1, e=1 on reg holding 8'hff -> t_out = 8'h01; without macro -> t_out = 8'hff.

Source files
------------

// File: rtl/tmp_bank_pkg.sv
// Shared types and default sizing for the tmp_bank register file.
// The optional forced-one read path is enabled by defining TMP_BANK_BUS1_EN.
package tmp_bank_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/tmp_bank_cell.sv
// One WIDTH-bit storage register with asynchronous reset, synchronous load and clear.
// Clear takes priority over load.
module tmp_bank_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] val_q;
   logic [WIDTH-1:0] val_d;

   always_comb begin
      val_d = val_q;
      if (clear) begin
         val_d = '0;
      end else if (load) begin
         val_d = d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign q = val_q;

endmodule

// File: rtl/tmp_bank.sv
// Small register bank with combinational read and a one-entry-per-cycle clear sweep.
// Define TMP_BANK_BUS1_EN to let bus1 force the read data to the value one.
module tmp_bank
   import tmp_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic [AW-1:0]    s_addr,
   input  logic [WIDTH-1:0] t_in,
   input  logic             e,
   input  logic [AW-1:0]    e_addr,
   input  logic             bus1,
   input  logic             clr,
   output logic [WIDTH-1:0] t_out,
   output logic             busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t          state_q;
   state_t          state_d;
   logic [AW-1:0]   idx_q;
   logic [AW-1:0]   idx_d;
   logic            wr_en;
   logic            sweep_en;
   logic [WIDTH-1:0] cell_q [DEPTH];
   logic [WIDTH-1:0] rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // The sweep ends on the edge that clears the last index, not on wrap.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         SWEEP: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // clr wins over a coincident write; writes are dropped while sweeping.
   always_comb begin
      busy     = (state_q == SWEEP);
      sweep_en = (state_q == SWEEP);
      wr_en    = (state_q == IDLE) && s && !clr;
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
         tmp_bank_cell #(
            .WIDTH (WIDTH)
         ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .load  (wr_en && (s_addr == AW'(gi))),
            .clear (sweep_en && (idx_q == AW'(gi))),
            .d     (t_in),
            .q     (cell_q[gi])
         );
      end
   endgenerate

   assign rd_data = e ? cell_q[e_addr] : '0;

`ifdef TMP_BANK_BUS1_EN
   assign t_out = bus1 ? WIDTH'(1) : rd_data;
`else
   logic bus1_unused;
   assign bus1_unused = bus1;
   assign t_out       = rd_data;
`endif

endmodule
